// File: rtl/riscv_mem_arb_if.sv
// rtl/riscv_mem_arb_if.sv - Fetch and load/store request/response bundle for riscv_mem_arb
interface riscv_mem_arb_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
    );
endinterface

// File: rtl/riscv_mem_arb.sv
// rtl/riscv_mem_arb.sv - Unified I/D memory with round-robin arbitration, sized accesses and wait states
module riscv_mem_arb #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    riscv_mem_arb_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_wait_cnt;
    logic        r_prefer_i;
    logic        r_pend_d;
    logic [31:0] r_pend_data;
    logic        r_pend_err;
    logic        r_i_rvalid;
    logic [31:0] r_i_rdata;
    logic        r_i_err;
    logic        r_d_rvalid;
    logic [31:0] r_d_rdata;
    logic        r_d_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_conflict;
    logic          w_gnt_d;
    logic          w_gnt_i;
    logic          w_grant;
    logic [31:0]   w_addr;
    logic          w_oor;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_d_bad;
    logic          w_err;
    logic [31:0]   w_load;
    logic [31:0]   w_rdata;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic          w_we;
    logic          w_wait_done;
    logic          w_emit;
    logic          w_emit_d;
    logic [31:0]   w_emit_data;
    logic          w_emit_err;

    // Grants are gated by rst so every output is quiet while reset is held.
    assign w_accept   = !rst && (r_state != S_WAIT);
    assign w_conflict = bus.d_req && bus.i_req;
    assign w_gnt_d    = w_accept && bus.d_req && (!bus.i_req || !r_prefer_i);
    assign w_gnt_i    = w_accept && bus.i_req && (!bus.d_req || r_prefer_i);
    assign w_grant    = w_gnt_d || w_gnt_i;

    assign w_addr = w_gnt_i ? bus.i_addr : bus.d_addr;
    assign w_oor  = |w_addr[31:AW+2];
    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_d_bad     = 1'b0;
        w_load      = w_word;
        w_be        = 4'b1111;
        w_wdata_rep = bus.d_wdata;
        case (bus.d_size)
            2'd0: begin
                w_load      = {{24{w_byte[7] & ~bus.d_unsigned}}, w_byte};
                w_be        = 4'b0001 << w_addr[1:0];
                w_wdata_rep = {4{bus.d_wdata[7:0]}};
            end
            2'd1: begin
                w_d_bad     = w_addr[0];
                w_load      = {{16{w_half[15] & ~bus.d_unsigned}}, w_half};
                w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{bus.d_wdata[15:0]}};
            end
            2'd2:    w_d_bad = |w_addr[1:0];
            default: w_d_bad = 1'b1;
        endcase
    end

    assign w_err   = w_gnt_i ? (w_oor || |bus.i_addr[1:0]) : (w_oor || w_d_bad);
    assign w_rdata = w_err   ? 32'd0 :
                     w_gnt_i ? w_word :
                     bus.d_we ? 32'd0 : w_load;
    assign w_we    = w_gnt_d && bus.d_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Response source: held capture after wait states, or the live grant when there are none.
    assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == 3'(WAIT_CYCLES - 1));
    assign w_emit      = w_wait_done || (w_grant && (WAIT_CYCLES == 0));
    assign w_emit_d    = w_wait_done ? r_pend_d    : w_gnt_d;
    assign w_emit_data = w_wait_done ? r_pend_data : w_rdata;
    assign w_emit_err  = w_wait_done ? r_pend_err  : w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 3'd0;
            r_prefer_i  <= 1'b0;
            r_pend_d    <= 1'b0;
            r_pend_data <= 32'd0;
            r_pend_err  <= 1'b0;
            r_i_rvalid  <= 1'b0;
            r_i_rdata   <= 32'd0;
            r_i_err     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= 32'd0;
            r_d_err     <= 1'b0;
        end else begin
            r_d_rvalid <= w_emit && w_emit_d;
            r_d_rdata  <= (w_emit && w_emit_d) ? w_emit_data : 32'd0;
            r_d_err    <= w_emit && w_emit_d && w_emit_err;
            r_i_rvalid <= w_emit && !w_emit_d;
            r_i_rdata  <= (w_emit && !w_emit_d) ? w_emit_data : 32'd0;
            r_i_err    <= w_emit && !w_emit_d && w_emit_err;

            if (w_grant && w_conflict) begin
                r_prefer_i <= w_gnt_d;
            end

            case (r_state)
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_state <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                default: begin
                    if (w_grant) begin
                        r_pend_d    <= w_gnt_d;
                        r_pend_data <= w_rdata;
                        r_pend_err  <= w_err;
                        r_wait_cnt  <= 3'd0;
                        r_state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.i_gnt    = w_gnt_i;
    assign bus.d_gnt    = w_gnt_d;
    assign bus.i_rvalid = r_i_rvalid;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.i_err    = r_i_err;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;
endmodule

// File: doc/riscv_mem_arb.md
Name: riscv_mem_arb

Overview:
- Unified instruction/data memory for the core, replacing the flat word-indexed RAM.
- Single storage array shared by an instruction-fetch port and a load/store port, with one array access per granted cycle.
- Adds byte-address decode, byte/half/word loads and stores with sign extension, request/grant handshake, round-robin arbitration, configurable wait states and error responses.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words (power of two, >= 4); byte address range 0 .. 4*DEPTH_WORDS-1
- WAIT_CYCLES, 0, extra cycles between grant and response (0..7)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until granted
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid (1-cycle pulse)
- i_rdata  out  32  fetched word
- i_err  out  1  fetch error, qualified by i_rvalid
- d_req  in  1  load/store request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- d_gnt  out  1  load/store accepted this cycle
- d_rvalid  out  1  response valid (loads and stores), 1-cycle pulse
- d_rdata  out  32  load data, extended to 32 bits
- d_err  out  1  error, qualified by d_rvalid

Behaviour:
- Reset: all outputs 0; FSM to IDLE; wait counter 0; round-robin pointer favours D. Memory contents are not reset. Reset mid-transaction drops the pending response, and no rvalid is issued for it.
- Request fields are sampled only in the grant cycle; requester may change them after gnt.
- Arbitration runs when FSM can accept:
  - only one req high: grant it;
  - both high: grant the port not granted at the last conflict, then flip the pointer;
  - at most one gnt per cycle; gnt is combinational from req and state.
- FSM states:
  - IDLE: accepts a grant and moves to WAIT when WAIT_CYCLES > 0, or to RESP when WAIT_CYCLES = 0.
  - WAIT: counter runs WAIT_CYCLES cycles, then moves to RESP.
  - RESP: rvalid high for the owning port for exactly one cycle; a new grant may be issued in the same cycle (goes to WAIT or RESP, otherwise IDLE).
  - With WAIT_CYCLES = 0, back-to-back grants every cycle give a sustained throughput of 1 response per cycle.
- Latency: response appears exactly 1 + WAIT_CYCLES cycles after the grant edge.
- Array access happens at the grant edge:
  - write performed at the grant edge;
  - read data captured at the grant edge and held until RESP;
  - accesses are therefore serialized in grant order, and a load granted after a store to the same word returns the new data.
- Word index = addr[log2(DEPTH_WORDS)+1 : 2]. Out of range when addr >= 4*DEPTH_WORDS.
- Stores:
  - byte writes lane addr[1:0];
  - half writes lanes {addr[1],0} and {addr[1],1};
  - word writes all lanes;
  - other lanes unchanged;
  - response rdata = 0.
- Loads:
  - select lane(s) by addr[1:0];
  - shift to bit 0;
  - sign- or zero-extend per d_unsigned (ignored for word).
- Fetch returns the full word; i_addr[1:0] must be 00.
- Error conditions (response still issued, err=1, rdata=0, no write):
  - d_size = 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - fetch with i_addr[1:0] != 0;
  - any out-of-range address.
- err and rdata are 0 whenever rvalid is 0.

Test Plan:
- Word store 0xDEADBEEF to 0x100, then word load 0x100 and fetch 0x100, WAIT_CYCLES=0 -> both return 0xDEADBEEF with err=0, each 1 cycle after its grant.
- Byte store 0x80 to 0x101 over word 0x11223344 -> word reads 0x11228044; signed byte load 0x101 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half load 0x102 -> 0x00001122.
- i_req and d_req both held high for 4 cycles -> grants go D, I, D, I; responses follow in grant order, one per cycle.
- WAIT_CYCLES=3, load granted at cycle t -> d_rvalid at t+4; no gnt during t+1..t+3; a request held high is granted at t+4.
- Half load 0x103, word store 0x102, d_size=3, fetch 0x4002, load 4*DEPTH_WORDS -> each returns err=1, rdata=0; the store leaves memory unchanged.
- rst asserted asynchronously during WAIT -> outputs 0 immediately, no rvalid follows; the next request after reset is granted to D on conflict.
